// File: rtl/motoro3_pwm_monitor_pkg.sv
// Shared types and constants for the motoro3 PWM monitor.
package motoro3_pkg;

  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_HIGH  = 2'd1,
    S_STUCK = 2'd2
  } pulse_state_e;

  localparam logic [11:0] PWM_MIN_NOMINAL = 12'd32;
  localparam logic [11:0] PWM_PERIOD_MAX  = 12'hFFF;

endpackage

// File: rtl/motoro3_pwm_monitor_if.sv
// Stimulus and report bundle between the PWM monitor and its surroundings.
interface motoro3_pwm_monitor_if #(
  parameter int CNT_W = 12
);
  logic             pwm;
  logic             winEnd;
  logic [11:0]      pwmMinMask;
  logic [15:0]      posACCwant;
  logic             stuckClr;
  logic [15:0]      pulseWidth;
  logic             pulseValid;
  logic             pulseShort;
  logic [15:0]      onTimeSum;
  logic [CNT_W-1:0] pulseCnt;
  logic [7:0]       shortCnt;
  logic [16:0]      errDelta;
  logic             winValid;
  logic             stuckHigh;

  modport master (
    output pwm, winEnd, pwmMinMask, posACCwant, stuckClr,
    input  pulseWidth, pulseValid, pulseShort, onTimeSum, pulseCnt,
           shortCnt, errDelta, winValid, stuckHigh
  );

  modport slave (
    input  pwm, winEnd, pwmMinMask, posACCwant, stuckClr,
    output pulseWidth, pulseValid, pulseShort, onTimeSum, pulseCnt,
           shortCnt, errDelta, winValid, stuckHigh
  );
endinterface

// File: rtl/motoro3_pwm_monitor_pulse_meter.sv
// Edge detection, pulse-state machine and width counter for one PWM line.
module motoro3_pulse_meter
  import motoro3_pkg::*;
#(
  parameter int STUCK_LIMIT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_i,
  input  logic [11:0] min_mask_i,
  input  logic        stuck_clr_i,
  output logic        fall_o,
  output logic        short_o,
  output logic [15:0] pulse_width_o,
  output logic        pulse_valid_o,
  output logic        pulse_short_o,
  output logic        stuck_high_o
);

  pulse_state_e state_q, state_d;
  logic [15:0]  width_q, width_d;
  logic         pwm_d_q;
  logic         rise, fall, short_fall, stuck_set;
  logic [15:0]  pulse_width_q;
  logic         pulse_valid_q, pulse_short_q, stuck_high_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rise       = pwm_i & ~pwm_d_q;
  assign fall       = ~pwm_i & pwm_d_q & (state_q != S_LOW);
  assign short_fall = fall & (width_q < {4'd0, min_mask_i});

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    stuck_set = 1'b0;
    case (state_q)
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          width_d = 16'd1;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
        end else begin
          width_d = sat_inc16(width_q);
          if (width_d >= 16'(STUCK_LIMIT)) begin
            state_d   = S_STUCK;
            stuck_set = 1'b1;
          end
        end
      end
      S_STUCK: begin
        if (fall) state_d = S_LOW;
        else      width_d = sat_inc16(width_q);
      end
      default: state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOW;
      width_q       <= '0;
      pwm_d_q       <= 1'b0;
      pulse_width_q <= '0;
      pulse_valid_q <= 1'b0;
      pulse_short_q <= 1'b0;
      stuck_high_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      pwm_d_q       <= pwm_i;
      pulse_valid_q <= fall;
      pulse_short_q <= short_fall;
      if (fall) pulse_width_q <= width_q;
      // A new stuck event beats a simultaneous clear.
      stuck_high_q  <= stuck_set | (stuck_high_q & ~stuck_clr_i);
    end
  end

  assign fall_o        = fall;
  assign short_o       = short_fall;
  assign pulse_width_o = pulse_width_q;
  assign pulse_valid_o = pulse_valid_q;
  assign pulse_short_o = pulse_short_q;
  assign stuck_high_o  = stuck_high_q;

endmodule

// File: rtl/motoro3_pwm_monitor.sv
// PWM receive-side monitor: pulse widths, short-pulse counts and per-window on-time report.
// Define MOTORO3_PWM_MON_SYNC_EN to put a 2-flop synchronizer on pwm (winEnd delayed to match).
module motoro3_pwm_monitor
  import motoro3_pkg::*;
#(
  parameter int STUCK_LIMIT = int'(PWM_PERIOD_MAX),
  parameter int CNT_W       = 12
) (
  input logic                  clk,
  input logic                  rst,
  motoro3_pwm_monitor_if.slave bus
);

  logic        pwm_s, win_end_s;
  logic [15:0] want_s;

`ifdef MOTORO3_PWM_MON_SYNC_EN
  logic [1:0]  pwm_sync_q, win_sync_q;
  logic [15:0] want_p1_q, want_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_sync_q <= '0;
      win_sync_q <= '0;
      want_p1_q  <= '0;
      want_p2_q  <= '0;
    end else begin
      pwm_sync_q <= {pwm_sync_q[0], bus.pwm};
      win_sync_q <= {win_sync_q[0], bus.winEnd};
      want_p1_q  <= bus.posACCwant;
      want_p2_q  <= want_p1_q;
    end
  end

  assign pwm_s     = pwm_sync_q[1];
  assign win_end_s = win_sync_q[1];
  assign want_s    = want_p2_q;
`else
  assign pwm_s     = bus.pwm;
  assign win_end_s = bus.winEnd;
  assign want_s    = bus.posACCwant;
`endif

  logic fall, short_fall;

  motoro3_pulse_meter #(
    .STUCK_LIMIT(STUCK_LIMIT)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .pwm_i        (pwm_s),
    .min_mask_i   (bus.pwmMinMask),
    .stuck_clr_i  (bus.stuckClr),
    .fall_o       (fall),
    .short_o      (short_fall),
    .pulse_width_o(bus.pulseWidth),
    .pulse_valid_o(bus.pulseValid),
    .pulse_short_o(bus.pulseShort),
    .stuck_high_o (bus.stuckHigh)
  );

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0]        on_acc_q, on_acc_d, on_total;
  logic [CNT_W-1:0]   pulse_acc_q, pulse_acc_d, pulse_total;
  logic [7:0]         short_acc_q, short_acc_d, short_total;
  logic signed [16:0] err_d, err_q;
  logic [15:0]        on_sum_q;
  logic [CNT_W-1:0]   pulse_cnt_q;
  logic [7:0]         short_cnt_q;
  logic               win_valid_q;

  // Totals include this cycle so the window-end sample lands in the closing window.
  always_comb begin
    on_total    = pwm_s      ? sat_inc16(on_acc_q)      : on_acc_q;
    pulse_total = fall       ? sat_inc_cnt(pulse_acc_q) : pulse_acc_q;
    short_total = short_fall ? sat_inc8(short_acc_q)    : short_acc_q;
    err_d       = $signed({1'b0, on_total}) - $signed({1'b0, want_s});
    on_acc_d    = win_end_s ? '0 : on_total;
    pulse_acc_d = win_end_s ? '0 : pulse_total;
    short_acc_d = win_end_s ? '0 : short_total;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      on_acc_q    <= '0;
      pulse_acc_q <= '0;
      short_acc_q <= '0;
      on_sum_q    <= '0;
      pulse_cnt_q <= '0;
      short_cnt_q <= '0;
      err_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      on_acc_q    <= on_acc_d;
      pulse_acc_q <= pulse_acc_d;
      short_acc_q <= short_acc_d;
      win_valid_q <= win_end_s;
      if (win_end_s) begin
        on_sum_q    <= on_total;
        pulse_cnt_q <= pulse_total;
        short_cnt_q <= short_total;
        err_q       <= err_d;
      end
    end
  end

  assign bus.onTimeSum = on_sum_q;
  assign bus.pulseCnt  = pulse_cnt_q;
  assign bus.shortCnt  = short_cnt_q;
  assign bus.errDelta  = err_q;
  assign bus.winValid  = win_valid_q;

endmodule

// File: doc/motoro3_pwm_monitor.md
Name: motoro3_pwm_monitor

Overview:
- Receive-side checker for the 3-phase PWM output: samples the generated `pwm` line and measures every pulse width.
- Counts pulses and pulses shorter than the MOSFET-driver minimum; accumulates on-time per commutation window.
- At window end, latches a report with signed error against the wanted accumulated position.
- Sits beside the PWM generator in the motor top level and feeds debug registers and the fault logic.

Parameters:
- STUCK_LIMIT, 4095, on-time in clk cycles (max PWM period 0xFFF) after which pwm counts as stuck high.
- CNT_W, 12, width of the per-window pulse counter.

Ports:
- clk  in  1  system clock, 10 MHz.
- rst  in  1  synchronous reset, active-high.
- pwm  in  1  PWM line under test, same clock domain.
- winEnd  in  1  one-cycle window-end strobe, aligned with the generator's second last-count strobe.
- pwmMinMask  in  12  minimum legal pulse width in clk cycles (nominal 32).
- posACCwant  in  16  wanted on-time for the window that is ending; valid while winEnd=1.
- stuckClr  in  1  clears stuckHigh.
- pulseWidth  out  16  width of the last completed pulse.
- pulseValid  out  1  one-cycle strobe; pulseWidth updated.
- pulseShort  out  1  qualifies pulseValid; width < pwmMinMask.
- onTimeSum  out  16  latched window on-time.
- pulseCnt  out  CNT_W  latched pulses completed in the window.
- shortCnt  out  8  latched short pulses in the window.
- errDelta  out  17  latched signed onTimeSum − posACCwant, two's complement.
- winValid  out  1  one-cycle strobe; window report updated.
- stuckHigh  out  1  sticky stuck-high fault.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, all counters 0, state S_LOW, pwmD=0.
- pwmD is pwm registered once. Rise = pwm&~pwmD; fall = ~pwm&pwmD.
- State machine: S_LOW, S_HIGH, S_STUCK.
  - S_LOW→S_HIGH on rise; widthCnt<=1.
  - S_HIGH: widthCnt+1 per high cycle.
  - S_HIGH→S_LOW on fall: pulseWidth<=widthCnt; pulseValid=1 and pulseShort=(widthCnt<pwmMinMask) for that one cycle. The strobe is registered, so it is visible the cycle after the first low sample.
  - S_HIGH→S_STUCK when widthCnt reaches STUCK_LIMIT: set stuckHigh. widthCnt saturates at 16'hFFFF.
  - S_STUCK→S_LOW on fall: report the pulse as normal (saturated width).
- stuckHigh is cleared only by rst or stuckClr. If stuckClr and a new stuck event occur in the same cycle, set wins.
- Window accumulators:
  - onAcc: +1 per cycle with pwm=1, saturating at 16'hFFFF.
  - pulseAcc: +1 per fall, saturating.
  - shortAcc: +1 per short fall, saturating at 8'hFF.
- winEnd cycle: latch totals that include the current cycle's pwm and fall events. errDelta={1'b0,total}−{1'b0,posACCwant}. Accumulators restart at 0 on the next cycle. winValid is asserted one cycle after the winEnd sample.
- A pulse spanning winEnd splits its on-time between the two windows. It is counted in pulseAcc only in the window where its fall occurs. widthCnt is not cleared by winEnd.
- winEnd held high on consecutive cycles: each cycle latches a one-cycle window.
- pwmMinMask=0: no pulse is short.
- Mid-operation rst discards the partial pulse and window; no strobe follows.

Optional Feature:
- Macro MOTORO3_PWM_MON_SYNC_EN.
- Defined: pwm passes through a 2-flop synchronizer before edge detection. All pulse events are delayed 2 cycles; winEnd is delayed by the same 2 stages so windows stay aligned. Synchronizer flops reset to 0.
- Undefined: pwm is sampled directly, with latencies as stated above.

Decomposition:
- Package motoro3_pkg holds:
  - State encoding (S_LOW=2'd0, S_HIGH=2'd1, S_STUCK=2'd2).
  - Constant PWM_MIN_NOMINAL=12'd32.
  - Constant PWM_PERIOD_MAX=12'hFFF.
- One sub-module, motoro3_pulse_meter: edge detect, state machine and widthCnt, outputting fall/width/short.
- Window accumulation and latch stay in the top module.

Test Plan:
- Rst released, pwm high for 100 cycles then low → pulseValid once, pulseWidth=100, pulseShort=0, stuckHigh=0.
- pwmMinMask=32, pulses of 20, 31, 32 cycles → pulseShort=1,1,0; next winEnd gives shortCnt=2, pulseCnt=3.
- 10 pulses of 50 cycles, winEnd with posACCwant=520 → onTimeSum=500, errDelta=−20 (17'h1FFEC), winValid one cycle after winEnd.
- Pulse of 60 cycles with winEnd at its 25th high cycle → window1 onTimeSum=25, pulseCnt=0; window2 onTimeSum=35, pulseCnt=1; pulseWidth=60.
- pwm held high 5000 cycles → stuckHigh after 4095 high cycles; on fall pulseWidth=5000; stuckClr → stuckHigh=0.
- rst asserted mid-pulse at width 40, pwm continues low → no pulseValid, all outputs 0.
